// File: rtl/alu_seq_pkg.sv
// Shared definitions for the multi-precision ALU operand sequencer.
// Latency: none (types and constants only).
// Backpressure: not applicable.
// Contents: FSM state encoding, wide operation codes, ALU logic operation codes.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Wide arithmetic operations (req_mode = 1)
  localparam logic [1:0] OP_TRANSFER = 2'b00;
  localparam logic [1:0] OP_ADD      = 2'b01;
  localparam logic [1:0] OP_SUB      = 2'b10;
  localparam logic [1:0] OP_RSUB     = 2'b11;

  // ALU logic operations (req_mode = 0), passed straight through
  localparam logic [1:0] LOP_AND  = 2'b00;
  localparam logic [1:0] LOP_OR   = 2'b01;
  localparam logic [1:0] LOP_XOR  = 2'b10;
  localparam logic [1:0] LOP_XNOR = 2'b11;

endpackage

// File: rtl/alu_slice_sel.sv
// Maps a wide operation onto ALU operands (inversion, carry-in) and extracts slice idx.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the selected slice is loaded.
// Ports: a/b/cin/oper/mode = wide operation, idx = slice number,
//        slice_a/slice_b = N-bit operands, c0 = carry into slice 0, alu_oper = ALU code,
//        a_msb/b_msb (only with ALU_MP_SEQ_OVF_EN) = sign bits of the mapped operands.
module alu_slice_sel
  import alu_seq_pkg::*;
#(
  parameter int N      = 4,
  parameter int SLICES = 4,
  parameter int IW     = 2
) (
  input  logic [N*SLICES-1:0] a,
  input  logic [N*SLICES-1:0] b,
  input  logic                cin,
  input  logic [1:0]          oper,
  input  logic                mode,
  input  logic [IW-1:0]       idx,
  output logic [N-1:0]        slice_a,
  output logic [N-1:0]        slice_b,
  output logic                c0,
  output logic [1:0]          alu_oper
`ifdef ALU_MP_SEQ_OVF_EN
  ,
  output logic                a_msb,
  output logic                b_msb
`endif
);

  localparam int W = N * SLICES;

  logic [W-1:0] a_m;
  logic [W-1:0] b_m;
  logic [W-1:0] sh_a;
  logic [W-1:0] sh_b;

  // Subtraction is done as two's complement addition on the whole wide operand,
  // because the ALU's own +1 only exists per slice and cannot be chained.
  always_comb begin
    a_m      = a;
    b_m      = b;
    c0       = 1'b0;
    alu_oper = oper;
    if (mode) begin
      alu_oper = OP_ADD;
      case (oper)
        OP_TRANSFER: alu_oper = OP_TRANSFER;
        OP_ADD:      c0 = cin;
        OP_SUB: begin
          b_m = ~b;
          c0  = 1'b1;
        end
        OP_RSUB: begin
          a_m = ~a;
          c0  = 1'b1;
        end
      endcase
    end
  end

  assign sh_a    = a_m >> (N * int'(idx));
  assign sh_b    = b_m >> (N * int'(idx));
  assign slice_a = sh_a[N-1:0];
  assign slice_b = sh_b[N-1:0];

`ifdef ALU_MP_SEQ_OVF_EN
  assign a_msb = a_m[W-1];
  assign b_msb = b_m[W-1];
`endif

endmodule

// File: rtl/alu_mp_sequencer.sv
// Runs one N*SLICES-bit operation through an N-bit registered ALU, LS slice first, carry chained.
// Latency: rsp_valid rises SLICES+1 edges after the accept edge; one op per SLICES+3 cycles.
// Backpressure: req_ready only in IDLE; response held stable in RESP until rsp_ready.
// Ports: Clk/rst (async, active-high); req_* = wide request (valid/ready);
//        alu_* = slice interface to the ALU (alu_Cin combinational, rest registered);
//        rsp_* = wide response (valid/ready). Option ALU_MP_SEQ_OVF_EN adds rsp_ovf.
module alu_mp_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N      = 4,
  parameter int SLICES = 4
) (
  input  logic                Clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [N*SLICES-1:0] req_a,
  input  logic [N*SLICES-1:0] req_b,
  input  logic                req_cin,
  input  logic [1:0]          req_oper,
  input  logic                req_mode,
  output logic [N-1:0]        alu_A,
  output logic [N-1:0]        alu_B,
  output logic                alu_Cin,
  output logic [1:0]          alu_Oper,
  output logic                alu_Mode,
  input  logic [N-1:0]        alu_Sum,
  input  logic                alu_Cout,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [N*SLICES-1:0] rsp_sum,
  output logic                rsp_cout
`ifdef ALU_MP_SEQ_OVF_EN
  ,
  output logic                rsp_ovf
`endif
);

  localparam int W  = N * SLICES;
  localparam int IW = $clog2(SLICES);

  state_t        state;
  logic [IW-1:0] idx;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          op_cin;
  logic [1:0]    op_oper;
  logic          op_mode;
  logic          op_c0;

  logic          is_idle;
  logic          is_arith;
  logic [W-1:0]  src_a;
  logic [W-1:0]  src_b;
  logic          src_cin;
  logic [1:0]    src_oper;
  logic          src_mode;
  logic [IW-1:0] sel_idx;
  logic [N-1:0]  sel_a;
  logic [N-1:0]  sel_b;
  logic          sel_c0;
  logic [1:0]    sel_oper;

`ifdef ALU_MP_SEQ_OVF_EN
  logic          sel_a_msb;
  logic          sel_b_msb;
  logic          op_a_msb;
  logic          op_b_msb;
`endif

  assign is_idle   = (state == IDLE);
  assign req_ready = is_idle;
  assign is_arith  = op_mode && (op_oper != OP_TRANSFER);

  // In IDLE the selector looks at the incoming request so slice 0 can be
  // loaded on the accept edge; afterwards it looks ahead to slice idx+1.
  assign src_a    = is_idle ? req_a    : op_a;
  assign src_b    = is_idle ? req_b    : op_b;
  assign src_cin  = is_idle ? req_cin  : op_cin;
  assign src_oper = is_idle ? req_oper : op_oper;
  assign src_mode = is_idle ? req_mode : op_mode;
  assign sel_idx  = is_idle ? '0 : idx + IW'(1);

  // The ALU registers its carry, so slice k>0 takes the carry of slice k-1 directly.
  assign alu_Cin = (idx == '0) ? op_c0 : alu_Cout;

  alu_slice_sel #(
    .N      (N),
    .SLICES (SLICES),
    .IW     (IW)
  ) u_sel (
    .a        (src_a),
    .b        (src_b),
    .cin      (src_cin),
    .oper     (src_oper),
    .mode     (src_mode),
    .idx      (sel_idx),
    .slice_a  (sel_a),
    .slice_b  (sel_b),
    .c0       (sel_c0),
    .alu_oper (sel_oper)
`ifdef ALU_MP_SEQ_OVF_EN
    ,
    .a_msb    (sel_a_msb),
    .b_msb    (sel_b_msb)
`endif
  );

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_cin    <= 1'b0;
      op_oper   <= 2'b00;
      op_mode   <= 1'b0;
      op_c0     <= 1'b0;
      alu_A     <= '0;
      alu_B     <= '0;
      alu_Oper  <= 2'b00;
      alu_Mode  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
`ifdef ALU_MP_SEQ_OVF_EN
      op_a_msb  <= 1'b0;
      op_b_msb  <= 1'b0;
      rsp_ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_a     <= req_a;
            op_b     <= req_b;
            op_cin   <= req_cin;
            op_oper  <= req_oper;
            op_mode  <= req_mode;
            op_c0    <= sel_c0;
            alu_A    <= sel_a;
            alu_B    <= sel_b;
            alu_Oper <= sel_oper;
            alu_Mode <= req_mode;
            idx      <= '0;
            state    <= RUN;
`ifdef ALU_MP_SEQ_OVF_EN
            op_a_msb <= sel_a_msb;
            op_b_msb <= sel_b_msb;
`endif
          end
        end
        RUN: begin
          // alu_Sum trails the issued slice by one edge
          if (idx != '0) begin
            rsp_sum[(int'(idx) - 1) * N +: N] <= alu_Sum;
          end
          if (idx == IW'(SLICES - 1)) begin
            state <= DRAIN;
          end else begin
            idx   <= idx + IW'(1);
            alu_A <= sel_a;
            alu_B <= sel_b;
          end
        end
        DRAIN: begin
          rsp_sum[(SLICES - 1) * N +: N] <= alu_Sum;
          rsp_cout  <= is_arith & alu_Cout;
          rsp_valid <= 1'b1;
          idx       <= '0;
          state     <= RESP;
`ifdef ALU_MP_SEQ_OVF_EN
          rsp_ovf   <= is_arith && (op_a_msb == op_b_msb) && (alu_Sum[N-1] != op_a_msb);
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
